// File: rtl/axil_app_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axil_app_arbiter
// Brief    : Round-robin arbiter sharing the axis_lite_m application port
//            among NUM_REQ requesters, with a per-transaction watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module axil_app_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         app_waddr,
    output logic [DATA_W-1:0]         app_wdata,
    output logic                      app_wen,
    input  logic                      app_wdone,
    output logic [ADDR_W-1:0]         app_raddr,
    output logic                      app_ren,
    input  logic [DATA_W-1:0]         app_rdata,
    input  logic                      app_rdone,
    output logic                      busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CAND_W = IDX_W + 1;
    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] c_wdog_last = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_gnt;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    w_win;
    logic [CAND_W-1:0]   w_cand;
    logic                w_any;
    logic                r_we;
    logic [WDOG_W-1:0]   r_wdog;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [ADDR_W-1:0]   r_app_waddr;
    logic [DATA_W-1:0]   r_app_wdata;
    logic [ADDR_W-1:0]   r_app_raddr;
    logic                w_done;
    logic                w_expire;

    // Search from r_rr_ptr upward with wrap; first requester found wins.
    always_comb begin
        w_any  = 1'b0;
        w_win  = r_rr_ptr;
        w_cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + CAND_W'(k);
            if (w_cand >= CAND_W'(NUM_REQ)) begin
                w_cand = w_cand - CAND_W'(NUM_REQ);
            end
            if (!w_any && req_valid[w_cand[IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_cand[IDX_W-1:0];
            end
        end
    end

    // Only the done matching the request type counts; a done wins over expiry.
    assign w_done   = r_we ? app_wdone : app_rdone;
    assign w_expire = (TIMEOUT != 0) && (r_wdog == c_wdog_last);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_rdata    = '0;
        rsp_err      = 1'b0;
        app_wen      = 1'b0;
        app_ren      = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                req_ready[r_gnt] = 1'b1;
                app_wen          = r_we;
                app_ren          = !r_we;
                w_state_next     = S_WAIT;
            end
            S_WAIT: begin
                if (w_done || w_expire) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[r_gnt] = 1'b1;
                rsp_rdata        = r_rdata;
                rsp_err          = r_err;
                w_state_next     = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_gnt       <= '0;
            r_rr_ptr    <= '0;
            r_we        <= 1'b0;
            r_wdog      <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_app_waddr <= '0;
            r_app_wdata <= '0;
            r_app_raddr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt <= w_win;
                        r_we  <= req_we[w_win];
                        if (req_we[w_win]) begin
                            r_app_waddr <= req_addr[w_win*ADDR_W +: ADDR_W];
                            r_app_wdata <= req_wdata[w_win*DATA_W +: DATA_W];
                        end else begin
                            r_app_raddr <= req_addr[w_win*ADDR_W +: ADDR_W];
                        end
                    end
                end
                S_ISSUE: begin
                    r_rr_ptr <= (r_gnt == c_last_idx) ? '0 : r_gnt + 1'b1;
                    r_wdog   <= '0;
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (w_done) begin
                        r_err   <= 1'b0;
                        r_rdata <= r_we ? '0 : app_rdata;
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign app_waddr = r_app_waddr;
    assign app_wdata = r_app_wdata;
    assign app_raddr = r_app_raddr;

endmodule
`default_nettype wire

// File: doc/axil_app_arbiter.md
# axil_app_arbiter

Round-robin arbiter that shares the single application port of the AXI-Lite master (`axis_lite_m`) among `NUM_REQ` independent requesters. It sits between the client logic and the master's `app_*` interface. It accepts one read or write request at a time, issues it to the master, waits for the matching completion, and routes the completion back to the originating requester. A watchdog retires a transaction that never completes so that a stuck slave cannot lock up every client.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 1024: cycles allowed in WAIT before forced retirement; 0 disables the watchdog.

Ports:
- `aclk`  in  1: clock; all logic on the rising edge.
- `aresetn`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ: per-client request; held high until `req_ready` for that client.
- `req_we`  in  NUM_REQ: per-client 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W: per-client address; client i occupies slice i.
- `req_wdata`  in  NUM_REQ*DATA_W: per-client write data.
- `req_ready`  out  NUM_REQ: one-cycle accept pulse, one-hot.
- `rsp_valid`  out  NUM_REQ: one-cycle completion pulse, one-hot.
- `rsp_rdata`  out  DATA_W: read data, valid with `rsp_valid`; 0 for writes.
- `rsp_err`  out  1: timeout flag, valid with `rsp_valid`.
- `app_waddr`, `app_wdata`  out  ADDR_W/DATA_W: connect to the master.
- `app_wen`  out  1: write start pulse to the master.
- `app_wdone`  in  1: write completion from the master.
- `app_raddr`  out  ADDR_W: connect to the master.
- `app_ren`  out  1: read start pulse to the master.
- `app_rdata`  in  DATA_W: read data from the master.
- `app_rdone`  in  1: read completion from the master.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, choose winner g by round-robin, searching from `rr_ptr` upward with wrap.
  - Register g, `req_we[g]`, `req_addr[g]` and `req_wdata[g]`.
  - Go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Assert `req_ready[g]`.
  - Assert `app_wen` if the request is a write, otherwise `app_ren`.
  - Set `rr_ptr` to (g+1) mod NUM_REQ.
  - Clear the watchdog counter.
  - Go to WAIT.
- **WAIT**
  - Increment the watchdog each cycle.
  - Write: leave on `app_wdone`. Read: leave on `app_rdone`, capturing `app_rdata` that same cycle.
  - The done signal of the opposite type is ignored.
  - If the watchdog reaches `TIMEOUT` (and `TIMEOUT` is not 0) without a done, set the error flag and capture read data as 0.
  - Go to RESP.
- **RESP** (exactly 1 cycle)
  - Assert `rsp_valid[g]`, `rsp_rdata` and `rsp_err`.
  - Go to IDLE.
- `app_waddr`/`app_wdata` (writes) or `app_raddr` (reads) are driven from the registered request and held stable from ISSUE until the next grant. The unused address/data outputs hold their last value.
- Done pulses arriving in IDLE, ISSUE or RESP are dropped. This covers a late completion after a timeout.
- Requests are not queued. A client whose `req_valid` drops before `req_ready` is simply not served.
- At most one transaction is outstanding in total.

## Timing
- Reset (async assert, sync-release use):
  - state IDLE, `rr_ptr` 0, watchdog 0.
  - `req_ready`, `rsp_valid`, `app_wen`, `app_ren`, `rsp_err`, `busy` all 0.
  - `rsp_rdata`, `app_waddr`, `app_wdata`, `app_raddr` all 0.
- Reset mid-transaction returns to IDLE immediately. No response is generated and `rr_ptr` returns to 0.
- Latency:
  - `req_valid` sampled in IDLE at cycle 0.
  - `req_ready` and `app_wen`/`app_ren` at cycle 1.
  - A done seen at cycle d gives `rsp_valid` at cycle d+1.
  - IDLE again at d+2. Minimum request-to-response is 3 cycles (done at cycle 2).
- Back-to-back: a new grant can be decided in the IDLE cycle at d+2, giving a minimum spacing of 4 cycles between issues.
- Simultaneous requests: exactly one grant per arbitration. The client at or just after `rr_ptr` wins.
- Timeout: in WAIT, the watchdog counts cycles after ISSUE. The retirement decision is taken on the cycle the count equals `TIMEOUT`, and RESP follows on the next cycle.

## Test plan
- **Single write.** Client 0 write, addr 0xAAAABBBB, data 0x5AA5A55A.
  - `app_wen` pulses 1 cycle with these values on `app_waddr`/`app_wdata`.
  - `app_wdone` 5 cycles later gives `rsp_valid`=0001, `rsp_err`=0.
- **Read.** Client 2 read, addr 0x10; slave returns 0xDEADBEEF.
  - `app_ren` pulses once.
  - `rsp_valid`=0100, `rsp_rdata`=0xDEADBEEF.
- **Fairness.** All 4 clients request continuously from reset.
  - Grants go in order 0,1,2,3,0,…
  - No client gets two grants before every other requester has had one.
- **Timeout.** `TIMEOUT`=16, slave never responds.
  - `rsp_valid` for the granted client occurs 16 cycles after ISSUE, plus 1 for RESP, with `rsp_err`=1.
  - A late `app_wdone` then produces no `rsp_valid`.
- **Reset mid-WAIT.**
  - `aresetn` low during WAIT immediately gives `busy`=0 and every output at its reset value.
  - After release, a new request from client 1 is granted normally.
- **Wrong-type done.** During a read, pulse `app_wdone`.
  - The arbiter stays in WAIT.
  - A later `app_rdone` completes the read normally.
